// File: rtl/fsmc_bus_ctrl_if.sv
// fsmc_bus_ctrl_if: bus bundle between the FSMC slave side, the controller and the four targets.
//   Slave side : stb_i, we_i, adr_i, dat_i -> controller; dat_o, ack_o -> slave
//   Target side: tgt_stb_o, tgt_we_o, tgt_adr_o, tgt_dat_o -> targets; tgt_dat_i, tgt_ack_i -> controller
//   modport master : controller view
//   modport slave  : environment (FSMC slave + targets) view
interface fsmc_bus_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 19,
    parameter int unsigned DATA_WIDTH = 16
);
    logic                    stb_i;
    logic                    we_i;
    logic [ADDR_WIDTH-1:0]   adr_i;
    logic [DATA_WIDTH-1:0]   dat_i;
    logic [DATA_WIDTH-1:0]   dat_o;
    logic                    ack_o;
    logic [3:0]              tgt_stb_o;
    logic                    tgt_we_o;
    logic [ADDR_WIDTH-3:0]   tgt_adr_o;
    logic [DATA_WIDTH-1:0]   tgt_dat_o;
    logic [4*DATA_WIDTH-1:0] tgt_dat_i;
    logic [3:0]              tgt_ack_i;

    modport master (
        input  stb_i, we_i, adr_i, dat_i, tgt_dat_i, tgt_ack_i,
        output dat_o, ack_o, tgt_stb_o, tgt_we_o, tgt_adr_o, tgt_dat_o
    );

    modport slave (
        output stb_i, we_i, adr_i, dat_i, tgt_dat_i, tgt_ack_i,
        input  dat_o, ack_o, tgt_stb_o, tgt_we_o, tgt_adr_o, tgt_dat_o
    );
endinterface

// File: rtl/fsmc_bus_ctrl.sv
// fsmc_bus_ctrl: bridges an asynchronous FSMC slave strobe onto four synchronous targets.
// The top two address bits select a target; the request is held until the selected
// target acks or TIMEOUT REQ cycles elapse, then ack_o pulses for one cycle.
// Ports:
//   clk_i, rst_ni   system clock, synchronous active-low reset
//   bus (master)    slave request/response and target strobe/ack signals
//   err_o           one-cycle pulse alongside ack_o when the access timed out
//   err_cnt_o       saturating timeout count
// Optional feature: define FSMC_BUS_CTRL_ERR_CNT_EN to build the timeout counter;
// otherwise err_cnt_o is tied to zero.
module fsmc_bus_ctrl #(
    parameter int unsigned ADDR_WIDTH = 19,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    fsmc_bus_ctrl_if.master      bus,
    output logic                 err_o,
    output logic [7:0]           err_cnt_o
);
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned TADR_W  = ADDR_WIDTH - 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, ACK, DONE} state_e;

    state_e                state_q, state_d;
    logic [2:0]            sync_q;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [1:0]            sel_q, sel_d;
    logic [3:0]            tgt_stb_q, tgt_stb_d;
    logic                  we_q, we_d;
    logic [TADR_W-1:0]     adr_q, adr_d;
    logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic                  req_c;
    logic                  sel_ack_c;

    // Two synchronizer flops plus one history flop; a request is the rising edge seen by flop 2.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], bus.stb_i};
        end
    end

    assign req_c     = sync_q[1] & ~sync_q[2];
    assign sel_ack_c = |(bus.tgt_ack_i & tgt_stb_q);

    // State and registered outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sel_q     <= '0;
            tgt_stb_q <= '0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            wdat_q    <= '0;
            dat_q     <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            tgt_stb_q <= tgt_stb_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            wdat_q    <= wdat_d;
            dat_q     <= dat_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

    // Next state and next registered output values.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        tgt_stb_d = tgt_stb_q;
        we_d      = we_q;
        adr_d     = adr_q;
        wdat_d    = wdat_q;
        dat_d     = dat_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_c) begin
                    state_d   = REQ;
                    cnt_d     = '0;
                    sel_d     = bus.adr_i[ADDR_WIDTH-1:ADDR_WIDTH-2];
                    tgt_stb_d = 4'(4'b0001 << bus.adr_i[ADDR_WIDTH-1:ADDR_WIDTH-2]);
                    we_d      = bus.we_i;
                    adr_d     = bus.adr_i[TADR_W-1:0];
                    wdat_d    = bus.dat_i;
                end
            end
            REQ: begin
                // A selected ack wins over a timeout landing on the same cycle.
                if (sel_ack_c) begin
                    state_d   = ACK;
                    tgt_stb_d = '0;
                    ack_d     = 1'b1;
                    if (!we_q) begin
                        dat_d = bus.tgt_dat_i[sel_q*DATA_WIDTH +: DATA_WIDTH];
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ACK;
                    tgt_stb_d = '0;
                    ack_d     = 1'b1;
                    err_d     = 1'b1;
                    if (!we_q) begin
                        dat_d = DATA_WIDTH'(16'hDEAD);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ACK: begin
                state_d = DONE;
            end
            DONE: begin
                if (!sync_q[1]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.tgt_stb_o = tgt_stb_q;
    assign bus.tgt_we_o  = we_q;
    assign bus.tgt_adr_o = adr_q;
    assign bus.tgt_dat_o = wdat_q;
    assign bus.dat_o     = dat_q;
    assign bus.ack_o     = ack_q;
    assign err_o         = err_q;

`ifdef FSMC_BUS_CTRL_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    // Saturating timeout counter, advanced by the err_o pulse.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_cnt_q <= '0;
        end else if (err_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fsmc_bus_ctrl.sv
// tb_fsmc_bus_ctrl: directed, table-driven bench for fsmc_bus_ctrl.
module tb_fsmc_bus_ctrl;
    localparam int unsigned AW = 19;
    localparam int unsigned DW = 16;

    logic       clk;
    logic       rst_n;
    logic       err;
    logic [7:0] err_cnt;
    int         checks;
    int         errors;
    int         exp_errcnt;

    fsmc_bus_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    fsmc_bus_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(64)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .bus       (bus),
        .err_o     (err),
        .err_cnt_o (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [18:0] adr;
        logic [15:0] wdat;
        logic [15:0] rdat;
        int          ack_at;   // REQ cycle index of the selected ack, -1 = never
        logic [3:0]  wrong;    // non-selected acks pulsed in REQ cycle 1
        logic [3:0]  exp_stb;
        logic [16:0] exp_adr;
        int          exp_hi;   // cycles tgt_stb_o stays high
        logic [15:0] exp_dat;
        logic        exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fill_tgt_data(input logic [1:0] sel, input logic [15:0] rdat);
        for (int n = 0; n < 4; n++) begin
            bus.tgt_dat_i[n*DW +: DW] = (n == int'(sel)) ? rdat : 16'(16'h1111 * (n + 1));
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int  hi;
        bit  got;
        fill_tgt_data(v.adr[18:17], v.rdat);
        bus.we_i  = v.we;
        bus.adr_i = v.adr;
        bus.dat_i = v.wdat;
        bus.stb_i = 1'b1;
        tick();
        tick();
        chk({tag, " stb_early"}, 64'(bus.tgt_stb_o), 64'h0);
        tick();
        chk({tag, " stb_edge3"}, 64'(bus.tgt_stb_o), 64'(v.exp_stb));
        chk({tag, " tgt_adr"}, 64'(bus.tgt_adr_o), 64'(v.exp_adr));
        chk({tag, " tgt_we"}, 64'(bus.tgt_we_o), 64'(v.we));
        if (v.we) chk({tag, " tgt_dat"}, 64'(bus.tgt_dat_o), 64'(v.wdat));
        hi  = 0;
        got = 0;
        for (int c = 0; c < 200 && !got; c++) begin
            if (bus.tgt_stb_o == v.exp_stb) hi++;
            if (c == v.ack_at)  bus.tgt_ack_i = v.exp_stb;
            else if (c == 1)    bus.tgt_ack_i = v.wrong;
            else                bus.tgt_ack_i = 4'h0;
            tick();
            if (bus.ack_o) got = 1;
        end
        bus.tgt_ack_i = 4'h0;
        chk({tag, " ack_seen"}, 64'(got), 64'h1);
        chk({tag, " stb_cycles"}, 64'(hi), 64'(v.exp_hi));
        chk({tag, " stb_off"}, 64'(bus.tgt_stb_o), 64'h0);
        chk({tag, " dat_o"}, 64'(bus.dat_o), 64'(v.exp_dat));
        chk({tag, " err"}, 64'(err), 64'(v.exp_err));
        tick();
        chk({tag, " ack_pulse"}, 64'({bus.ack_o, err}), 64'h0);
        bus.stb_i = 1'b0;
        for (int i = 0; i < 4; i++) tick();
`ifdef FSMC_BUS_CTRL_ERR_CNT_EN
        if (v.exp_err) exp_errcnt++;
`endif
        chk({tag, " err_cnt"}, 64'(err_cnt), 64'(exp_errcnt));
    endtask

    initial begin
        int gotack;
        checks     = 0;
        errors     = 0;
        exp_errcnt = 0;

        //            we    adr         wdat     rdat     ack  wrong  stb      adr        hi  dat_o    err
        vecs[0] = '{1'b0, 19'h4_0012, 16'h0,    16'hA5A5, 4,  4'h0, 4'b0100, 17'h0_0012, 5,  16'hA5A5, 1'b0};
        vecs[1] = '{1'b1, 19'h0_0100, 16'h1234, 16'h7777, 2,  4'h0, 4'b0001, 17'h0_0100, 3,  16'hA5A5, 1'b0};
        vecs[2] = '{1'b0, 19'h6_0ABC, 16'h0,    16'h4321, -1, 4'h0, 4'b1000, 17'h0_0ABC, 64, 16'hDEAD, 1'b1};
        vecs[3] = '{1'b0, 19'h2_0055, 16'h0,    16'h5A5A, 5,  4'h9, 4'b0010, 17'h0_0055, 6,  16'h5A5A, 1'b0};
        vecs[4] = '{1'b0, 19'h2_7FFF, 16'h0,    16'hBEEF, 63, 4'h0, 4'b0010, 17'h0_7FFF, 64, 16'hBEEF, 1'b0};
        vecs[5] = '{1'b1, 19'h5_1357, 16'hCAFE, 16'h0,    -1, 4'h0, 4'b0100, 17'h1_1357, 64, 16'hBEEF, 1'b1};
        vecs[6] = '{1'b0, 19'h0_0001, 16'h0,    16'h0F0F, 0,  4'hE, 4'b0001, 17'h0_0001, 1,  16'h0F0F, 1'b0};

        bus.stb_i     = 1'b0;
        bus.we_i      = 1'b1;
        bus.adr_i     = 19'h7_FFFF;
        bus.dat_i     = 16'hFFFF;
        bus.tgt_dat_i = '1;
        bus.tgt_ack_i = 4'h0;
        rst_n         = 1'b0;
        tick();
        tick();
        chk("reset_slave", 64'({bus.dat_o, bus.ack_o, err, err_cnt}), 64'h0);
        chk("reset_tgt", 64'({bus.tgt_stb_o, bus.tgt_we_o, bus.tgt_adr_o, bus.tgt_dat_o}), 64'h0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Acks while idle must not complete anything or move dat_o.
        bus.tgt_ack_i = 4'hF;
        bus.tgt_dat_i = '0;
        tick();
        tick();
        bus.tgt_ack_i = 4'h0;
        chk("idle_ack_ignored", 64'({bus.ack_o, bus.tgt_stb_o}), 64'h0);
        chk("idle_dat_kept", 64'(bus.dat_o), 64'h0F0F);

        // Reset in the middle of REQ with stb_i held high.
        fill_tgt_data(2'd1, 16'h2468);
        bus.we_i  = 1'b0;
        bus.adr_i = 19'h2_0033;
        bus.stb_i = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("rst_pre_req", 64'(bus.tgt_stb_o), 64'h2);
        rst_n  = 1'b0;
        gotack = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.ack_o) gotack = 1;
        end
        chk("rst_mid_outputs", 64'({bus.tgt_stb_o, bus.dat_o, bus.ack_o, err, err_cnt}), 64'h0);
        rst_n = 1'b1;
        tick();
        if (bus.ack_o) gotack = 1;
        tick();
        if (bus.ack_o) gotack = 1;
        chk("rst_no_ack", 64'(gotack), 64'h0);
        chk("rst_stb_early", 64'(bus.tgt_stb_o), 64'h0);
        tick();
        chk("rst_stb_edge3", 64'(bus.tgt_stb_o), 64'h2);
        bus.tgt_ack_i = 4'b0010;
        tick();
        bus.tgt_ack_i = 4'h0;
        chk("rst_resume_ack", 64'({bus.ack_o, err}), 64'h2);
        chk("rst_resume_dat", 64'(bus.dat_o), 64'h2468);
        bus.stb_i = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
